// File: rtl/axi_duth_w_slave_mem.sv
// AXI4 write-channel responder with a byte-strobed internal memory and a backdoor read port.
// Optional macro AXI_W_SLAVE_LAST_CHECK_EN: flag SLVERR when w_last does not match the burst length.
module axi_duth_w_slave_mem #(
    parameter int unsigned AXI_MODE      = 4,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned LEN_WIDTH     = 8,
    parameter int unsigned SIZE_WIDTH    = 3,
    parameter int unsigned BURST_WIDTH   = 2,
    parameter int unsigned AW_TID_WIDTH  = 1,
    parameter int unsigned W_DATA_WIDTH  = 64,
    parameter int unsigned B_RESP_WIDTH  = 2,
    parameter int unsigned MEM_WORDS     = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         aw_valid,
    output logic                         aw_ready,
    input  logic [AW_TID_WIDTH-1:0]      aw_tid,
    input  logic [ADDRESS_WIDTH-1:0]     aw_addr,
    input  logic [LEN_WIDTH-1:0]         aw_len,
    input  logic [SIZE_WIDTH-1:0]        aw_size,
    input  logic [BURST_WIDTH-1:0]       aw_burst,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [AW_TID_WIDTH-1:0]      w_tid,
    input  logic [W_DATA_WIDTH-1:0]      w_data,
    input  logic [W_DATA_WIDTH/8-1:0]    w_strb,
    input  logic                         w_last,
    output logic                         b_valid,
    input  logic                         b_ready,
    output logic [AW_TID_WIDTH-1:0]      b_tid,
    output logic [B_RESP_WIDTH-1:0]      b_resp,
    input  logic [$clog2(MEM_WORDS)-1:0] dbg_raddr,
    output logic [W_DATA_WIDTH-1:0]      dbg_rdata
);

    localparam int unsigned STRB_W  = W_DATA_WIDTH / 8;
    localparam int unsigned OFF_W   = $clog2(STRB_W);
    localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
    localparam int unsigned RANGE_W = OFF_W + IDX_W;

    localparam logic [SIZE_WIDTH-1:0]   MAX_SIZE    = SIZE_WIDTH'(OFF_W);
    localparam logic [BURST_WIDTH-1:0]  BURST_FIXED = BURST_WIDTH'(0);
    localparam logic [BURST_WIDTH-1:0]  BURST_INCR  = BURST_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0]  BURST_WRAP  = BURST_WIDTH'(2);
    localparam logic [BURST_WIDTH-1:0]  BURST_RSVD  = BURST_WIDTH'(3);
    localparam logic [B_RESP_WIDTH-1:0] RESP_OKAY   = B_RESP_WIDTH'(0);
    localparam logic [B_RESP_WIDTH-1:0] RESP_SLVERR = B_RESP_WIDTH'(2);

    typedef enum logic [1:0] {StIdle, StData, StResp} state_t;

    state_t                   state_q, state_d;
    logic                     rst_done_q;
    logic [AW_TID_WIDTH-1:0]  tid_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]     len_q;
    logic [SIZE_WIDTH-1:0]    size_q;
    logic [BURST_WIDTH-1:0]   burst_q;
    logic [LEN_WIDTH:0]       cnt_q;
    logic                     err_q;

    logic [W_DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic                     aw_hs, w_hs, b_hs;
    logic [ADDRESS_WIDTH-1:0] aw_beat, beat_sz, wrap_span, addr_next;
    logic                     wrap_len_ok, aw_err;
    logic                     in_range, cnt_ok, tid_err, last_err, beat_err, mem_we;
    logic [IDX_W-1:0]         word_idx;

    // aw_ready stays low while rst is asserted, hence the extra registered flag.
    assign aw_ready = (state_q == StIdle) && rst_done_q;
    assign w_ready  = (state_q == StData);
    assign b_valid  = (state_q == StResp);
    assign b_tid    = (state_q == StResp) ? tid_q : '0;
    assign b_resp   = ((state_q == StResp) && err_q) ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs = aw_valid && aw_ready;
    assign w_hs  = w_valid && w_ready;
    assign b_hs  = b_valid && b_ready;

    assign aw_beat     = ADDRESS_WIDTH'(1) << aw_size;
    assign wrap_len_ok = (aw_len == LEN_WIDTH'(1)) || (aw_len == LEN_WIDTH'(3)) ||
                         (aw_len == LEN_WIDTH'(7)) || (aw_len == LEN_WIDTH'(15));
    assign aw_err      = (aw_burst == BURST_RSVD) || (aw_size > MAX_SIZE) ||
                         ((aw_burst == BURST_WRAP) &&
                          (!wrap_len_ok || ((aw_addr & (aw_beat - 1'b1)) != '0)));

    assign beat_sz   = ADDRESS_WIDTH'(1) << size_q;
    assign wrap_span = (ADDRESS_WIDTH'(len_q) + ADDRESS_WIDTH'(1)) << size_q;

    always_comb begin
        addr_next = addr_q;
        unique case (burst_q)
            BURST_FIXED: addr_next = addr_q;
            BURST_INCR:  addr_next = (addr_q & ~(beat_sz - 1'b1)) + beat_sz;
            BURST_WRAP:  addr_next = (addr_q & ~(wrap_span - 1'b1)) |
                                     ((addr_q + beat_sz) & (wrap_span - 1'b1));
            default:     addr_next = addr_q;
        endcase
    end

    assign in_range = (addr_q >> RANGE_W) == '0;
    assign cnt_ok   = cnt_q <= {1'b0, len_q};
    assign tid_err  = (AXI_MODE == 3) && (w_tid != tid_q);
    assign word_idx = addr_q[OFF_W +: IDX_W];

`ifdef AXI_W_SLAVE_LAST_CHECK_EN
    assign last_err = (w_last && (cnt_q != {1'b0, len_q})) || !cnt_ok;
`else
    assign last_err = 1'b0;
`endif

    assign beat_err = !in_range || tid_err || last_err;
    assign mem_we   = w_hs && in_range && !err_q && cnt_ok && !tid_err && !rst;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (aw_hs)           state_d = StData;
            StData:  if (w_hs && w_last)  state_d = StResp;
            StResp:  if (b_hs)            state_d = StIdle;
            default:                      state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rst_done_q <= 1'b0;
            tid_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
            if (aw_hs) begin
                tid_q   <= aw_tid;
                addr_q  <= aw_addr;
                len_q   <= aw_len;
                size_q  <= aw_size;
                burst_q <= aw_burst;
                cnt_q   <= '0;
                err_q   <= aw_err;
            end else if (w_hs) begin
                if (beat_err) err_q <= 1'b1;
                if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                addr_q <= addr_next;
            end
        end
    end

    // Memory has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) mem[word_idx][b*8 +: 8] <= w_data[b*8 +: 8];
            end
        end
    end

    assign dbg_rdata = mem[dbg_raddr];

endmodule

// File: tb/tb_axi_duth_w_slave_mem.sv
// Self-checking bench for axi_duth_w_slave_mem: burst-level memory/response model plus literal pins.
// Honours AXI_W_SLAVE_LAST_CHECK_EN for the expected response of the early-w_last burst.
module tb_axi_duth_w_slave_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        aw_valid, aw_ready;
    logic        aw_tid;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_valid, w_ready, w_tid, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_valid, b_ready, b_tid;
    logic [1:0]  b_resp;
    logic [7:0]  dbg_raddr;
    logic [63:0] dbg_rdata;

    always #5 clk = ~clk;

    axi_duth_w_slave_mem #(
        .AXI_MODE(4), .ADDRESS_WIDTH(32), .LEN_WIDTH(8), .SIZE_WIDTH(3), .BURST_WIDTH(2),
        .AW_TID_WIDTH(1), .W_DATA_WIDTH(64), .B_RESP_WIDTH(2), .MEM_WORDS(256)
    ) dut (
        .clk(clk), .rst(rst),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_tid(aw_tid), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_tid(w_tid), .w_data(w_data),
        .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_tid(b_tid), .b_resp(b_resp),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    // Model state
    logic [63:0] mmem [256];
    bit          known [256];
    int unsigned m_addr;
    bit          m_err;
    int          m_cnt, m_len, m_size, m_burst;
    logic        m_tid;
    bit          resp_armed;
    logic        exp_tid;
    logic [1:0]  exp_resp;
    bit          chk_en;
    int          nchecks = 0;
    int          nerr = 0;
    logic [7:0]  strb_q [$];
    logic [63:0] data_q [$];

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic void model_aw(logic tid, int unsigned addr, int len, int size, int burst);
        m_tid = tid; m_addr = addr; m_len = len; m_size = size; m_burst = burst; m_cnt = 0;
        m_err = (burst == 3) || (size > 3) ||
                (burst == 2 && (!(len == 1 || len == 3 || len == 7 || len == 15) ||
                                (addr % (1 << size)) != 0));
    endfunction

    function automatic void model_beat(logic [63:0] data, logic [7:0] strb, bit last);
        int unsigned sz, span, lower, nxt;
        int w;
        if (m_addr >= 2048) m_err = 1;
        else if (!m_err && m_cnt <= m_len) begin
            w = int'(m_addr / 8);
            for (int b = 0; b < 8; b++) if (strb[b]) mmem[w][b*8 +: 8] = data[b*8 +: 8];
            if (strb == 8'hFF) known[w] = 1;
        end
`ifdef AXI_W_SLAVE_LAST_CHECK_EN
        if ((last && m_cnt != m_len) || m_cnt > m_len) m_err = 1;
`endif
        m_cnt++;
        sz = 1 << m_size;
        if (m_burst == 1) m_addr = m_addr - (m_addr % sz) + sz;
        else if (m_burst == 2) begin
            span  = (m_len + 1) * sz;
            lower = m_addr - (m_addr % span);
            nxt   = m_addr + sz;
            if (nxt >= lower + span) nxt = lower;
            m_addr = nxt;
        end
    endfunction

    task automatic send_aw(logic tid, logic [31:0] addr, logic [7:0] len, logic [2:0] size,
                           logic [1:0] burst);
        int n = 0;
        aw_valid = 1; aw_tid = tid; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
        while (!aw_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!aw_ready) check("aw_ready_timeout", {63'b0, aw_ready}, 1);
        @(posedge clk); #1;
        aw_valid = 0;
        model_aw(tid, addr, int'(len), int'(size), int'(burst));
        check("w_ready_after_aw", {63'b0, w_ready}, 1);
        check("aw_ready_after_aw", {63'b0, aw_ready}, 0);
    endtask

    task automatic send_w(logic [63:0] data, logic [7:0] strb, bit last);
        int n = 0;
        w_valid = 1; w_tid = m_tid; w_data = data; w_strb = strb; w_last = last;
        while (!w_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!w_ready) check("w_ready_timeout", {63'b0, w_ready}, 1);
        @(posedge clk); #1;
        w_valid = 0; w_last = 0;
        model_beat(data, strb, last);
        if (last) begin
            resp_armed = 1; exp_tid = m_tid; exp_resp = m_err ? 2'b10 : 2'b00;
            check("b_valid_after_last", {63'b0, b_valid}, 1);
        end
    endtask

    task automatic finish_b(int hold, logic want_tid, logic [1:0] want_resp);
        logic       t0;
        logic [1:0] r0;
        int n = 0;
        b_ready = 0; t0 = b_tid; r0 = b_resp;
        repeat (hold) begin
            @(posedge clk); #1;
            check("b_valid_held", {63'b0, b_valid}, 1);
            check("b_tid_stable", {63'b0, b_tid}, {63'b0, t0});
            check("b_resp_stable", {62'b0, b_resp}, {62'b0, r0});
        end
        check("b_tid_literal", {63'b0, b_tid}, {63'b0, want_tid});
        check("b_resp_literal", {62'b0, b_resp}, {62'b0, want_resp});
        b_ready = 1;
        while (!b_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (!b_valid) check("b_valid_timeout", {63'b0, b_valid}, 1);
        @(posedge clk); #1;
        b_ready = 0; resp_armed = 0;
        check("b_valid_after_hs", {63'b0, b_valid}, 0);
        check("aw_ready_after_b", {63'b0, aw_ready}, 1);
    endtask

    task automatic run_burst(logic tid, logic [31:0] addr, logic [7:0] len, logic [2:0] size,
                             logic [1:0] burst, int nbeats, int last_at, logic [63:0] dbase,
                             int hold, logic [1:0] want);
        logic [63:0] d;
        logic [7:0]  s;
        send_aw(tid, addr, len, size, burst);
        for (int i = 0; i < nbeats; i++) begin
            d = (i < data_q.size()) ? data_q[i] : dbase + 64'(i);
            s = (i < strb_q.size()) ? strb_q[i] : 8'hFF;
            send_w(d, s, i == last_at);
        end
        data_q.delete(); strb_q.delete();
        finish_b(hold, tid, want);
    endtask

    // Compare process: backdoor memory sweep and B channel against the model every cycle.
    initial begin
        dbg_raddr = '0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (known[dbg_raddr]) check("mem_word", dbg_rdata, mmem[dbg_raddr]);
                if (resp_armed && b_valid) begin
                    check("b_tid_model", {63'b0, b_tid}, {63'b0, exp_tid});
                    check("b_resp_model", {62'b0, b_resp}, {62'b0, exp_resp});
                end else if (!resp_armed) begin
                    check("b_spurious", {63'b0, b_valid}, 0);
                end
                dbg_raddr = dbg_raddr + 8'd1;
            end
        end
    end

    initial begin
        logic [1:0] last_resp;
        rst = 1; aw_valid = 0; aw_tid = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        w_valid = 0; w_tid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
        resp_armed = 0; chk_en = 0;
        for (int i = 0; i < 256; i++) known[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("aw_ready_in_reset", {63'b0, aw_ready}, 0);
        rst = 0;
        @(posedge clk); #1;
        check("rst_aw_ready", {63'b0, aw_ready}, 1);
        check("rst_w_ready", {63'b0, w_ready}, 0);
        check("rst_b_valid", {63'b0, b_valid}, 0);
        check("rst_b_tid", {63'b0, b_tid}, 0);
        check("rst_b_resp", {62'b0, b_resp}, 0);
        chk_en = 1;

        // Fill the whole memory so every word is known to the model.
        send_aw(0, 32'h0, 8'd255, 3'd3, 2'b01);
        for (int i = 0; i < 256; i++)
            send_w(64'h0123456789ABCDEF ^ (64'(i) * 64'h0001000100010001), 8'hFF, i == 255);
        finish_b(0, 0, 2'b00);

        // INCR: words 2..5 <- A0..A3
        run_burst(1, 32'h10, 8'd3, 3'd3, 2'b01, 4, 3, 64'hA0, 0, 2'b00);
        check("model_incr_w2", mmem[2], 64'hA0);
        check("model_incr_w5", mmem[5], 64'hA3);

        // WRAP: words 3,0,1,2 <- B0..B3
        run_burst(0, 32'h18, 8'd3, 3'd3, 2'b10, 4, 3, 64'hB0, 0, 2'b00);
        check("model_wrap_w3", mmem[3], 64'hB0);
        check("model_wrap_w0", mmem[0], 64'hB1);
        check("model_wrap_w2", mmem[2], 64'hB3);

        // FIXED on word 7 with merging strobes
        data_q = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333};
        strb_q = '{8'h0F, 8'hF0, 8'h01};
        run_burst(1, 32'h38, 8'd2, 3'd3, 2'b00, 3, 2, 64'h0, 0, 2'b00);
        check("model_fixed_w7", mmem[7], 64'h2222222211111133);

        // Top of memory: first beat lands in word 255, second is out of range
        run_burst(0, 32'h7F8, 8'd1, 3'd3, 2'b01, 2, 1, 64'hC0, 0, 2'b10);
        check("model_oor_w255", mmem[255], 64'hC0);

        // Reserved burst type: nothing written
        run_burst(1, 32'h30, 8'd0, 3'd3, 2'b11, 1, 0, 64'hDD, 0, 2'b10);
        check("model_rsvd_w6", mmem[6], 64'h0125456189ADCDE9);

        // Early w_last on a len=3 burst
`ifdef AXI_W_SLAVE_LAST_CHECK_EN
        last_resp = 2'b10;
`else
        last_resp = 2'b00;
`endif
        run_burst(0, 32'h40, 8'd3, 3'd3, 2'b01, 2, 1, 64'hD0, 0, last_resp);

        // B stall for 5 cycles, then reset in the middle of the next burst
        run_burst(1, 32'h60, 8'd0, 3'd3, 2'b01, 1, 0, 64'hE0, 5, 2'b00);
        send_aw(0, 32'h80, 8'd3, 3'd3, 2'b01);
        send_w(64'hF0, 8'hFF, 0);
        rst = 1;
        @(posedge clk); #1;
        check("midrst_aw_ready", {63'b0, aw_ready}, 0);
        check("midrst_w_ready", {63'b0, w_ready}, 0);
        check("midrst_b_valid", {63'b0, b_valid}, 0);
        rst = 0;
        @(posedge clk); #1;
        check("postrst_aw_ready", {63'b0, aw_ready}, 1);
        check("postrst_w_ready", {63'b0, w_ready}, 0);
        check("postrst_b_valid", {63'b0, b_valid}, 0);
        check("model_rst_w16", mmem[16], 64'hF0);
        check("model_rst_w12", mmem[12], 64'hE0);

        run_burst(1, 32'h88, 8'd0, 3'd3, 2'b01, 1, 0, 64'h77, 0, 2'b00);

        // Let the backdoor sweep visit every word once more.
        repeat (260) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
